// File: rtl/rom_share_arb.sv
// Round-robin arbiter sharing one 1-cycle-latency synchronous ROM between two readers.
// Grants are combinational; the tag pipeline tracks each read so responses return 2 clocks after accept.
module rom_share_arb #(
    parameter int  WIDTH = 1,
    parameter int  DEPTH = 19200,
    localparam int ADDRW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [ADDRW-1:0] req0_addr,
    output logic             req0_ready,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_data,
    input  logic             req1_valid,
    input  logic [ADDRW-1:0] req1_addr,
    output logic             req1_ready,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_data,
    output logic [ADDRW-1:0] rom_addr,
    input  logic [WIDTH-1:0] rom_data
);

    localparam logic [ADDRW:0] DEPTH_LIM = (ADDRW + 1)'(DEPTH);

    logic             last_reg;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             grant_id;
    logic [ADDRW-1:0] grant_addr;

    logic             s1_valid_reg;
    logic             s1_id_reg;
    logic             s1_oor_reg;
    logic             s2_valid_reg;
    logic             s2_id_reg;
    logic             s2_oor_reg;

    // On contention the requester that did not win last time gets the slot.
    always_comb begin
        grant0     = req0_valid && (!req1_valid || last_reg);
        grant1     = req1_valid && !grant0;
        accept     = grant0 || grant1;
        grant_id   = grant1;
        grant_addr = grant1 ? req1_addr : req0_addr;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr     <= '0;
            last_reg     <= 1'b1;
            s1_valid_reg <= 1'b0;
            s1_id_reg    <= 1'b0;
            s1_oor_reg   <= 1'b0;
            s2_valid_reg <= 1'b0;
            s2_id_reg    <= 1'b0;
            s2_oor_reg   <= 1'b0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                rom_addr   <= grant_addr;
                last_reg   <= grant_id;
                s1_id_reg  <= grant_id;
                s1_oor_reg <= ({1'b0, grant_addr} >= DEPTH_LIM);
            end
            // Stage 2 lines up with the cycle in which rom_data holds this read's word.
            s2_valid_reg <= s1_valid_reg;
            s2_id_reg    <= s1_id_reg;
            s2_oor_reg   <= s1_oor_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
            logic             valid_reg;
            logic [WIDTH-1:0] data_reg;
            logic             hit;

            assign hit = s2_valid_reg && (s2_id_reg == 1'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                end else begin
                    valid_reg <= hit;
                    if (hit) begin
                        data_reg <= s2_oor_reg ? '0 : rom_data;
                    end
                end
            end
        end
    endgenerate

    assign rsp0_valid = g_rsp[0].valid_reg;
    assign rsp0_data  = g_rsp[0].data_reg;
    assign rsp1_valid = g_rsp[1].valid_reg;
    assign rsp1_data  = g_rsp[1].data_reg;

endmodule

// File: tb/tb_rom_share_arb.sv
// Self-checking bench for rom_share_arb: directed scenarios then random stress,
// scored against a queue-based model of the arbitration and response rules.
module tb_rom_share_arb;

    localparam int W     = 8;
    localparam int DEPTH = 19200;
    localparam int ADDRW = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic [ADDRW-1:0] req0_addr, req1_addr;
    logic             req0_ready, req1_ready;
    logic             rsp0_valid, rsp1_valid;
    logic [W-1:0]     rsp0_data, rsp1_data;
    logic [ADDRW-1:0] rom_addr;
    logic [W-1:0]     rom_data;

    rom_share_arb #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data)
    );

    always #5 clk = ~clk;

    // Image ROM content as a pure function of the address.
    function automatic logic [W-1:0] rom_word(input int a);
        logic [31:0] t;
        t = a * 131 + (a >> 4);
        return t[W-1:0] ^ 8'hA5;
    endfunction

    // Synchronous ROM with one cycle of read latency; out-of-range reads return garbage.
    always @(posedge clk) begin
        if (int'(rom_addr) < DEPTH) rom_data <= rom_word(int'(rom_addr));
        else                        rom_data <= W'($urandom);
    end

    typedef struct {
        int         due;
        bit         id;
        logic [W-1:0] data;
    } item_t;

    item_t            pend[$];
    bit               last_m;
    logic [W-1:0]     held0, held1;
    logic [ADDRW-1:0] exp_rom_addr;
    int               cyc;
    int               vectors    = 0;
    int               miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        pend.delete();
        last_m       = 1'b1;
        held0        = '0;
        held1        = '0;
        exp_rom_addr = '0;
    endfunction

    // One clock of stimulus: drive, check at the falling edge, then advance the model.
    task automatic step(input bit v0, input logic [ADDRW-1:0] a0,
                        input bit v1, input logic [ADDRW-1:0] a1);
        bit               g0, g1, ev0, ev1;
        logic [ADDRW-1:0] a;
        item_t            it;
        req0_valid = v0; req0_addr = a0;
        req1_valid = v1; req1_addr = a1;
        @(negedge clk);
        g0 = v0 && (!v1 || last_m);
        g1 = v1 && !g0;
        chk("req0_ready", 32'(req0_ready), 32'(g0));
        chk("req1_ready", 32'(req1_ready), 32'(g1));
        chk("dual_ready", 32'(req0_ready & req1_ready), 32'd0);
        ev0 = 1'b0; ev1 = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            it = pend.pop_front();
            if (it.id) begin ev1 = 1'b1; held1 = it.data; end
            else       begin ev0 = 1'b1; held0 = it.data; end
        end
        chk("rsp0_valid", 32'(rsp0_valid), 32'(ev0));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(ev1));
        chk("rsp0_data",  32'(rsp0_data),  32'(held0));
        chk("rsp1_data",  32'(rsp1_data),  32'(held1));
        chk("rom_addr",   32'(rom_addr),   32'(exp_rom_addr));
        if (g0 || g1) begin
            a = g1 ? a1 : a0;
            it.due  = cyc + 3;
            it.id   = g1;
            it.data = (int'(a) >= DEPTH) ? '0 : rom_word(int'(a));
            pend.push_back(it);
            last_m       = g1;
            exp_rom_addr = a;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
    endtask

    // Asynchronous assert shortly after an edge, release on a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr = '0; req1_addr = '0;
        #2;
        model_reset();
        chk("rst_rom_addr",   32'(rom_addr),   32'd0);
        chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        chk("rst_rsp0_data",  32'(rsp0_data),  32'd0);
        chk("rst_rsp1_data",  32'(rsp1_data),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        cyc = 0;
        model_reset();
        #1;
        do_reset();

        // Single requester stream on port 0.
        for (int i = 0; i < 10; i++) step(1'b1, ADDRW'(i), 1'b0, '0);
        idle(4);

        // Continuous contention right after reset: grants must alternate 0,1,...
        do_reset();
        for (int i = 0; i < 8; i++) begin
            chk("contend_last", 32'(last_m), 32'(i % 2 == 0));
            step(1'b1, ADDRW'(100 + i), 1'b1, ADDRW'(200 + i));
        end
        idle(4);

        // Priority memory: port 1 alone, then both -> port 0 then port 1.
        step(1'b0, '0, 1'b1, ADDRW'(33));
        step(1'b1, ADDRW'(44), 1'b1, ADDRW'(55));
        step(1'b1, ADDRW'(45), 1'b1, ADDRW'(56));
        idle(4);

        // Out-of-range address followed by address 0.
        step(1'b1, ADDRW'(DEPTH), 1'b0, '0);
        step(1'b1, ADDRW'(0), 1'b0, '0);
        idle(4);

        // Reset while a read is in flight; no response may emerge.
        step(1'b1, ADDRW'(5), 1'b0, '0);
        step(1'b0, '0, 1'b0, '0);
        do_reset();
        idle(4);
        step(1'b1, ADDRW'(7), 1'b1, ADDRW'(8));
        idle(4);

        // Random stress on both ports, including some out-of-range addresses.
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), ADDRW'($urandom_range(0, DEPTH + 40)),
                 1'($urandom_range(0, 1)), ADDRW'($urandom_range(0, DEPTH + 40)));
        end
        idle(5);
        chk("drain_empty", 32'(pend.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case the stimulus loop ever stalls.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rom_share_arb.md
# rom_share_arb

Two-port round-robin arbiter that shares one synchronous image ROM (1-cycle read latency, e.g. the 160x120 mono image ROM) between two independent readers, such as the display scan-out path and a sprite/overlay engine. Each requester issues addresses through a valid/ready handshake. Each requester receives its read data on a fixed-latency response strobe with no backpressure. The block sits between the requesters and the ROM's `addr`/`data` pins and owns the ROM address bus exclusively.

## Interface
- `WIDTH`, default 1: ROM data width in bits.
- `DEPTH`, default 19200 (160*120): number of ROM words.
- `ADDRW`, localparam = $clog2(DEPTH): address width.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req0_valid` in 1: requester 0 has an address to read.
- `req0_addr` in ADDRW: requester 0 read address.
- `req0_ready` out 1: requester 0 address accepted this cycle.
- `rsp0_valid` out 1: one-cycle strobe; `rsp0_data` is valid.
- `rsp0_data` out WIDTH: read data for requester 0.
- `req1_valid`, `req1_addr`, `req1_ready`, `rsp1_valid`, `rsp1_data`: same as requester 0, for requester 1.
- `rom_addr` out ADDRW: registered address to the ROM.
- `rom_data` in WIDTH: ROM output, valid one cycle after the ROM samples `rom_addr`.

## Operation
- Acceptance occurs when `reqN_valid && reqN_ready` at a rising edge. At most one request is accepted per cycle, and a request can be accepted every cycle.
- Grant logic is combinational from `req*_valid` and the priority pointer `last`. `last` is a 1-bit record of the most recently granted requester.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester that is not `last` is granted.
  - Neither valid: no grant, and `last` is unchanged.
- `req0_ready` and `req1_ready` are never high together. `reqN_ready` is never high while `reqN_valid` is low.
- On acceptance:
  - `rom_addr` is loaded with the granted address.
  - `last` is updated to the granted requester.
  - Stage-1 tag {valid, id, oor} is loaded. `oor` is set when addr >= DEPTH.
- With no acceptance, `rom_addr` holds its value and the stage-1 valid bit clears.
- The stage-1 tag advances to stage 2 in step with ROM latency.
- At stage 2, `rspN_valid` pulses for the tagged id. `rspN_data` is the captured `rom_data`, or all-zero if `oor` is set. `rspN_data` holds its value until the next response to the same requester.
- Out-of-range addresses are still accepted and still occupy their slot. `rom_addr` is driven with the raw value; the ROM result is discarded.
- Responses are returned in acceptance order. Responses carry no ready signal, so requesters must always sink them.

## Timing
- Request accepted at edge E:
  - `rom_addr` is valid after E.
  - The ROM samples the address at E+1.
  - `rspN_valid`/`rspN_data` are registered at E+2 and high for the cycle following E+2.
- Request-to-response latency is 2 clocks. Back-to-back accepts give back-to-back responses.
- Under continuous contention, grants alternate 0,1,0,1,… Each requester gets exactly 50% of the bandwidth; neither can starve.
- Reset (asynchronous assert, synchronous-safe deassert externally) sets:
  - `rom_addr`=0, `rsp0_valid`=`rsp1_valid`=0, `rsp0_data`=`rsp1_data`=0.
  - Pipeline valids=0.
  - `last`=1, so requester 0 wins the first contended cycle.
- Reset mid-operation discards all in-flight responses. No `rspN_valid` appears for requests accepted before reset.
- `reqN_ready` is combinational. Requesters must not make `reqN_valid` depend on `reqN_ready`.

## Test plan
- Single requester: req0 streams addr 0..9 continuously with req1 idle. Expect `req0_ready`=1 every cycle, `rsp0_valid` on 10 consecutive cycles starting 2 clocks after the first accept, data matching the ROM image, and `rsp1_valid` never set.
- Contention: both requesters valid for 8 cycles after reset. Expect grant order 0,1,0,1,0,1,0,1, with 4 responses each in address order, each 2 clocks after its accept.
- Priority memory: req1 alone for 1 cycle, then both valid. Expect the next grant to go to req0, then req1.
- Out-of-range: req0 addr=DEPTH (19200) followed by addr=0. Expect both accepted, first `rsp0_data`=0 regardless of `rom_data`, and the second response to carry ROM word 0.
- Reset mid-flight: accept req0 addr 5, then assert `rst` at E+1. Expect no `rsp0_valid`; after release, all outputs at 0, and the first contended grant goes to req0.
- Random stress: random valid/addr on both ports for 10k cycles, checked against a reference model. Expect 100% of accepts answered exactly once, in order, with correct data, and never a dual ready.
